// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word fall-through byte FIFO for a UART receive path.
//               It keeps sticky overflow and underflow error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rd_en,
    input  logic          clear_err,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_ONE   = (AW+1)'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic          w_pop_empty;

    assign w_empty     = (count_q == '0);
    assign w_full      = (count_q == c_DEPTH);
    assign w_pop       = rd_en && !w_empty;
    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    assign w_wr        = rx_valid && (!w_full || w_pop);
    assign w_drop      = rx_valid && w_full && !w_pop;
    assign w_pop_empty = rd_en && w_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (w_wr && !w_pop) begin
            count_d = count_q + c_ONE;
        end else if (w_pop && !w_wr) begin
            count_d = count_q - c_ONE;
        end

        // A new error event wins over a clear issued on the same edge.
        if (clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_drop) begin
            overflow_d = 1'b1;
        end
        if (w_pop_empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; the empty gating on rd_data hides stale bytes.
    always_ff @(posedge clk) begin
        if (w_wr && !reset) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rd_data   = w_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
`default_nettype wire
